if_id_ctrl: RTL and testbench

- Pipeline control unit that sequences the IF/ID pipeline register and the PC.
- Generates PC write-enable, IF/ID write-enable, IF/ID flush and ID/EX bubble.
- Inputs: load-use hazards, branch-predictor miss (the `hit` bit carried through IF/ID) and instruction-memory wait.
- Sits beside the IF/ID register in the top-level CPU. Its outputs gate the register's latch and clear its contents.

---
 rtl/if_id_ctrl.sv | 170 +++++++++++++++++
 tb/tb_if_id_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_ctrl.sv
// if_id_ctrl: IF/ID pipeline-register and PC sequencing control.
// Combinational stall/flush/bubble controls are derived from a small
// RUN/FLUSH/IMISS state machine plus the current hazard inputs.
// Optional stall performance counter: define IF_ID_PERF_CNT_EN.
module if_id_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MISS_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             br_resolved,
    input  logic             pred_hit,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             imiss_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        IMISS = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MISS_LIMIT   = 8'(MISS_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       err_set;
    logic       mispredict;
    logic       load_use;

    assign mispredict = br_resolved & ~pred_hit;
    assign load_use   = ex_mem_read & (ex_rt != 5'd0) &
                        ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign state = state_q;

    // State register, flush/miss counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            miss_cnt_q  <= 8'd0;
            imiss_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (err_set) imiss_err <= 1'b1;
        end
    end

    // Next-state, counter updates and zero-latency pipeline controls.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_set      = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mispredict) begin
                    // Redirect the PC and squash the wrong-path fetch.
                    if_id_flush  = 1'b1;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    // Hold PC and IF/ID; the bubble resolves the hazard.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (!imem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = IMISS;
                    miss_cnt_d   = 8'd1;
                end
            end

            FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                pc_write     = imem_ready;
                if_id_write  = 1'b0;
                if (mispredict) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end

            IMISS: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (mispredict) begin
                    // A redirect abandons the outstanding fetch.
                    if_id_flush = 1'b1;
                    pc_write    = 1'b1;
                    miss_cnt_d  = 8'd0;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (imem_ready) begin
                    state_d    = RUN;
                    miss_cnt_d = 8'd0;
                end else begin
                    if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
                    if (miss_cnt_d >= MISS_LIMIT) err_set = 1'b1;
                end
            end

            default: begin
                // Unreachable encoding: stall safely and recover to RUN.
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                state_d      = RUN;
                flush_cnt_d  = 3'd0;
                miss_cnt_d   = 8'd0;
            end
        endcase
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles in which IF/ID did not accept a new instruction.
    always_ff @(posedge clk) begin
        if (rst)                              stall_cnt_q <= '0;
        else if (!if_id_write && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed self-checking bench for if_id_ctrl (FLUSH_CYCLES=3, MISS_TIMEOUT=4).
module tb_if_id_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_mem_read, br_resolved, pred_hit, imem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, imiss_err;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    if_id_ctrl #(.FLUSH_CYCLES(3), .MISS_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .br_resolved(br_resolved),
        .pred_hit(pred_hit), .imem_ready(imem_ready), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .imiss_err(imiss_err), .state(state),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational outputs mid-cycle (on the falling edge).
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
        ex_mem_read = 1'b0; br_resolved = 1'b0; pred_hit = 1'b1; imem_ready = 1'b1;
    endtask

    task automatic miss();
        br_resolved = 1'b1; pred_hit = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        mid();
        check("rst_state", state, 0);
        check("rst_pcw", pc_write, 1);
        check("rst_ifw", if_id_write, 1);
        check("rst_err", imiss_err, 0);
        check("rst_cnt", stall_count, 0);
        cyc();

        // Load-use via rs, then twice via rt.
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        mid();
        check("lu_pcw", pc_write, 0);
        check("lu_ifw", if_id_write, 0);
        check("lu_bub", id_ex_bubble, 1);
        check("lu_fl", if_id_flush, 0);
        cyc();
        id_rs = 5'd1; id_rt = 5'd5;
        mid(); check("lu_rt_ifw", if_id_write, 0);
        cyc(); cyc();
        idle();
        mid();
        check("lu_after_pcw", pc_write, 1);
        check("lu_after_bub", id_ex_bubble, 0);
        cyc();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        mid();
        check("lu_r0_ifw", if_id_write, 1);
        check("lu_r0_pcw", pc_write, 1);
        cyc();
        idle();

        // Mispredict: three flushed cycles, RUN->FLUSH->FLUSH->RUN.
        miss();
        mid();
        check("mp0_fl", if_id_flush, 1);
        check("mp0_pcw", pc_write, 1);
        check("mp0_ifw", if_id_write, 0);
        check("mp0_st", state, 0);
        cyc();
        idle();
        mid();
        check("mp1_st", state, 1);
        check("mp1_fl", if_id_flush, 1);
        check("mp1_pcw", pc_write, 1);
        cyc();
        mid();
        check("mp2_st", state, 1);
        check("mp2_fl", if_id_flush, 1);
        cyc();
        mid();
        check("mp3_st", state, 0);
        check("mp3_fl", if_id_flush, 0);
        check("mp3_ifw", if_id_write, 1);
`ifdef IF_ID_PERF_CNT_EN
        check("perf_cnt", stall_count, 6);
`else
        check("perf_cnt", stall_count, 0);
`endif
        cyc();

        // Priority: mispredict beats load-use; correct prediction is no-op.
        miss(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
        mid();
        check("pri_fl", if_id_flush, 1);
        check("pri_pcw", pc_write, 1);
        cyc();
        idle();
        cyc(); cyc();
        br_resolved = 1'b1; pred_hit = 1'b1;
        mid();
        check("hit_st", state, 0);
        check("hit_fl", if_id_flush, 0);
        check("hit_ifw", if_id_write, 1);
        cyc();
        idle();

        // IMISS timeout: ready low for 6 cycles, error after 4th edge.
        imem_ready = 1'b0;
        mid();
        check("im0_pcw", pc_write, 0);
        check("im0_bub", id_ex_bubble, 1);
        check("im0_st", state, 0);
        cyc();
        mid(); check("im1_st", state, 2);
        cyc(); cyc();
        mid(); check("im3_err", imiss_err, 0);
        cyc();
        mid(); check("im4_err", imiss_err, 1);
        cyc(); cyc();
        imem_ready = 1'b1;
        mid();
        check("im6_st", state, 2);
        check("im6_ifw", if_id_write, 0);
        cyc();
        mid();
        check("im7_st", state, 0);
        check("im7_err", imiss_err, 1);
        check("im7_ifw", if_id_write, 1);
        cyc();

        // Reset mid-IMISS.
        imem_ready = 1'b0;
        cyc(); cyc();
        mid(); check("rim_pre_st", state, 2);
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; imem_ready = 1'b1;
        mid();
        check("rim_st", state, 0);
        check("rim_pcw", pc_write, 1);
        check("rim_ifw", if_id_write, 1);
        check("rim_err", imiss_err, 0);
        check("rim_cnt", stall_count, 0);
        cyc();

        // Mispredict during IMISS, then FLUSH reload by a second mispredict.
        imem_ready = 1'b0;
        cyc();
        miss();
        mid();
        check("mi_st", state, 2);
        check("mi_fl", if_id_flush, 1);
        check("mi_pcw", pc_write, 1);
        check("mi_ifw", if_id_write, 0);
        cyc();
        br_resolved = 1'b0; pred_hit = 1'b1;
        mid();
        check("mi_fst", state, 1);
        check("mi_fpcw", pc_write, 0);
        check("mi_ffl", if_id_flush, 1);
        cyc();
        imem_ready = 1'b1;
        miss();
        cyc();
        idle();
        mid(); check("rl1_st", state, 1);
        cyc();
        mid(); check("rl2_st", state, 1);
        cyc();
        mid();
        check("rl3_st", state, 0);
        check("rl3_err", imiss_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
